// File: rtl/aes_encrypt_iter.sv
// rtl/aes_encrypt_iter.sv - iterative AES-128 encryption core, one round per clock
// Consumes a precomputed 1280-bit round-key schedule; one block in flight, result held until taken.
module aes_encrypt_iter #(
   parameter int LATCH_KEYS = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [127:0]  plaintext,
   input  logic [127:0]  key,
   input  logic [1279:0] round_keys,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [127:0]  ciphertext,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   state_t         state_q, state_d;
   logic [3:0]     round_q, round_d;
   logic [127:0]   st_q, st_d;
   logic           out_valid_q, out_valid_d;
   logic           accept;
   logic [1279:0]  rk_all;
   logic [127:0]   rk_cur;
   logic [127:0]   sr;

   // Entry for byte b sits at bit 2047-8*b, which is {~b, 3'b111}.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b111} -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int i = 0; i < 4; i++)
            r[127-8*(4*c+i) -: 8] = sbox(s[127-8*(4*((c+i)%4)+i) -: 8]);
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      for (int c = 0; c < 4; c++)
         r[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
      return r;
   endfunction

   assign in_ready   = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign accept     = in_valid & in_ready;
   assign out_valid  = out_valid_q;
   assign ciphertext = out_valid_q ? st_q : '0;
   assign busy       = (state_q != IDLE);
   assign sr         = sub_shift(st_q);

   generate
      if (LATCH_KEYS != 0) begin : g_latch
         logic [1279:0] rk_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      rk_q <= '0;
            else if (accept) rk_q <= round_keys;
         end
         assign rk_all = rk_q;
      end else begin : g_direct
         assign rk_all = round_keys;
      end
   endgenerate

   always_comb begin
      rk_cur = '0;
      for (int r = 1; r <= 10; r++)
         if (round_q == 4'(r)) rk_cur = rk_all[1279-(r-1)*128 -: 128];
   end

   always_comb begin
      state_d     = state_q;
      round_d     = round_q;
      st_d        = st_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = RUN;
            st_d    = plaintext ^ key;
            round_d = 4'd1;
         end
         RUN: begin
            if (round_q >= 4'd1 && round_q <= 4'd9) begin
               st_d    = mix_columns(sr) ^ rk_cur;
               round_d = round_q + 4'd1;
            end else if (round_q == 4'd10) begin
               st_d        = sr ^ rk_cur;
               state_d     = DONE;
               out_valid_d = 1'b1;
               round_d     = 4'd0;
            end else begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               round_d     = 4'd0;
            end
         end
         DONE: if (out_ready) begin
            out_valid_d = 1'b0;
            round_d     = 4'd0;
            state_d     = IDLE;
            if (accept) begin
               state_d = RUN;
               st_d    = plaintext ^ key;
               round_d = 4'd1;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            round_d     = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         round_q     <= '0;
         st_q        <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_q     <= round_d;
         st_q        <= st_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb/tb_aes_encrypt_iter.sv - self-checking bench for aes_encrypt_iter
// Reference AES is built from GF(2^8) arithmetic (S-box derived by inversion + affine map).
module tb_aes_encrypt_iter;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [127:0]  plaintext = '0;
   logic [127:0]  key = '0;
   logic [1279:0] round_keys = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [127:0]  ciphertext;
   logic          busy;

   int checks = 0;
   int errors = 0;
   logic [7:0] sbox_m [256];

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   aes_encrypt_iter #(.LATCH_KEYS(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .plaintext(plaintext), .key(key), .round_keys(round_keys),
      .out_valid(out_valid), .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   function automatic void build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endfunction

   function automatic logic [1279:0] key_expand(input logic [127:0] k);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rcon;
      logic [1279:0] rk;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
            t = t ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 1; r <= 10; r++)
         rk[1279-(r-1)*128 -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return rk;
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
      logic [7:0]    s [16];
      logic [7:0]    t [16];
      logic [7:0]    coef [4];
      logic [1279:0] rk;
      logic [127:0]  rkr, res;
      coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      rk = key_expand(k);
      for (int n = 0; n < 16; n++) s[n] = p[127-8*n -: 8] ^ k[127-8*n -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int n = 0; n < 16; n++) s[n] = sbox_m[s[n]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
         s = t;
         if (r < 10) begin
            for (int c = 0; c < 4; c++)
               for (int row = 0; row < 4; row++) begin
                  t[4*c+row] = 8'h00;
                  for (int j = 0; j < 4; j++)
                     t[4*c+row] = t[4*c+row] ^ gmul(coef[(j-row+4)%4], s[4*c+j]);
               end
            s = t;
         end
         rkr = rk[1279-(r-1)*128 -: 128];
         for (int n = 0; n < 16; n++) s[n] = s[n] ^ rkr[127-8*n -: 8];
      end
      for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
      return res;
   endfunction

   task automatic set_inputs(input logic [127:0] k, input logic [127:0] p);
      key        = k;
      plaintext  = p;
      round_keys = key_expand(k);
   endtask

   task automatic start_block(input logic [127:0] k, input logic [127:0] p);
      set_inputs(k, p);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic take_output();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (ciphertext !== 128'h0) begin errors++; $display("FAIL reset_ciphertext got=%h exp=0", ciphertext); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++; if ({busy, out_valid} !== 2'b00) begin errors++; $display("FAIL idle_after_reset got=%b exp=00", {busy, out_valid}); end
   endtask

   task automatic test_fips_c1();
      int lat;
      set_inputs(C1_KEY, C1_PT);
      in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL c1_in_ready got=%b exp=1", in_ready); end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++; if ({busy, out_valid} !== 2'b10) begin errors++; $display("FAIL c1_running got=%b exp=10", {busy, out_valid}); end
      wait_out(lat);
      checks++; if (lat !== 10) begin errors++; $display("FAIL c1_latency got=%0d exp=10", lat); end
      checks++; if (ciphertext !== C1_CT) begin errors++; $display("FAIL c1_ct got=%h exp=%h", ciphertext, C1_CT); end
      take_output();
      checks++; if ({busy, out_valid} !== 2'b00) begin errors++; $display("FAIL c1_after_take got=%b exp=00", {busy, out_valid}); end
   endtask

   task automatic test_fips_b();
      int lat;
      logic [1279:0] rk;
      rk = key_expand(B_KEY);
      checks++; if (rk[127:0] !== B_RK10) begin errors++; $display("FAIL b_rk10 got=%h exp=%h", rk[127:0], B_RK10); end
      start_block(B_KEY, B_PT);
      wait_out(lat);
      checks++; if (lat !== 10) begin errors++; $display("FAIL b_latency got=%0d exp=10", lat); end
      checks++; if (ciphertext !== B_CT) begin errors++; $display("FAIL b_ct got=%h exp=%h", ciphertext, B_CT); end
      take_output();
   endtask

   task automatic test_backpressure();
      int lat;
      start_block(C1_KEY, C1_PT);
      wait_out(lat);
      set_inputs(B_KEY, {$urandom, $urandom, $urandom, $urandom});
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         checks++; if ({out_valid, ciphertext} !== {1'b1, C1_CT}) begin errors++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/%h", i, out_valid, ciphertext, C1_CT); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      end
      set_inputs(B_KEY, B_PT);
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++; if ({busy, out_valid} !== 2'b10) begin errors++; $display("FAIL bp_reaccept got=%b exp=10", {busy, out_valid}); end
      wait_out(lat);
      checks++; if (lat !== 10) begin errors++; $display("FAIL bp_latency got=%0d exp=10", lat); end
      checks++; if (ciphertext !== B_CT) begin errors++; $display("FAIL bp_ct got=%h exp=%h", ciphertext, B_CT); end
      take_output();
   endtask

   task automatic test_busy_input();
      int lat;
      start_block(C1_KEY, C1_PT);
      repeat (4) @(posedge clk);
      #1;
      in_valid = 1'b1;
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready got=%b exp=0", in_ready); end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_out(lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL busy_latency got=%0d exp=5", lat); end
      checks++; if (ciphertext !== C1_CT) begin errors++; $display("FAIL busy_ct got=%h exp=%h", ciphertext, C1_CT); end
      take_output();
   endtask

   task automatic test_latch_keys();
      int lat;
      start_block(C1_KEY, C1_PT);
      key = '0;
      round_keys = '0;
      wait_out(lat);
      checks++; if (lat !== 10) begin errors++; $display("FAIL latch_latency got=%0d exp=10", lat); end
      checks++; if (ciphertext !== C1_CT) begin errors++; $display("FAIL latch_ct got=%h exp=%h", ciphertext, C1_CT); end
      take_output();
   endtask

   task automatic test_reset_mid();
      int lat;
      start_block(C1_KEY, C1_PT);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if ({out_valid, busy, in_ready} !== 3'b001) begin errors++; $display("FAIL midreset_flags got=%b exp=001", {out_valid, busy, in_ready}); end
      checks++; if (ciphertext !== 128'h0) begin errors++; $display("FAIL midreset_ct got=%h exp=0", ciphertext); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      start_block(C1_KEY, C1_PT);
      wait_out(lat);
      checks++; if (lat !== 10) begin errors++; $display("FAIL rerun_latency got=%0d exp=10", lat); end
      checks++; if (ciphertext !== C1_CT) begin errors++; $display("FAIL rerun_ct got=%h exp=%h", ciphertext, C1_CT); end
      take_output();
   endtask

   task automatic test_back_to_back();
      logic [127:0] ks [4];
      logic [127:0] ps [4];
      logic [127:0] exp_q [$];
      int lat;
      for (int i = 0; i < 4; i++) begin
         ks[i] = {$urandom, $urandom, $urandom, $urandom};
         ps[i] = {$urandom, $urandom, $urandom, $urandom};
         exp_q.push_back(aes_ref(ks[i], ps[i]));
      end
      out_ready = 1'b1;
      start_block(ks[0], ps[0]);
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin
            set_inputs(ks[i+1], ps[i+1]);
            in_valid = 1'b1;
         end
         wait_out(lat);
         checks++; if (lat !== 10) begin errors++; $display("FAIL b2b_latency[%0d] got=%0d exp=10", i, lat); end
         checks++; if (ciphertext !== exp_q[0]) begin errors++; $display("FAIL b2b_ct[%0d] got=%h exp=%h", i, ciphertext, exp_q[0]); end
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, in_ready); end
         void'(exp_q.pop_front());
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         checks++; if ({busy, out_valid} !== {(i < 3), 1'b0}) begin errors++; $display("FAIL b2b_after[%0d] got=%b exp=%b0", i, {busy, out_valid}, (i < 3)); end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [127:0] k, p, exp;
      int lat;
      for (int i = 0; i < 12; i++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         p = {$urandom, $urandom, $urandom, $urandom};
         exp = aes_ref(k, p);
         start_block(k, p);
         wait_out(lat);
         checks++; if (lat !== 10) begin errors++; $display("FAIL rand_latency[%0d] got=%0d exp=10", i, lat); end
         checks++; if (ciphertext !== exp) begin errors++; $display("FAIL rand_ct[%0d] got=%h exp=%h", i, ciphertext, exp); end
         repeat ($urandom_range(0, 4)) @(posedge clk);
         #1;
         take_output();
      end
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_fips_c1();
      test_fips_b();
      test_backpressure();
      test_busy_input();
      test_latch_keys();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
